full_bcd_to_led: RTL and testbench
==================================

# full_bcd_to_led

Four-digit free-running decimal counter (0000–9999) that drives four 7-segment displays directly. Each clock tick advances the count, and each BCD digit is decoded to a 7-segment pattern. `LED_TYPE` selects common-cathode (active-high) or common-anode (active-low) segment polarity. The block sits at the display edge of the design and needs no external data input.

## Interface

Parameters:
- `TICK_DIV`, default 1: number of `clk` rising edges per count increment; legal range ≥1.

Ports:
- `clk`  in  1: counter clock; rising-edge active.
- `enable`  in  1: the block's reset; one clock, reset asynchronous and active-high. While high, the count is forced to 0000.
- `LED_TYPE`  in  1: segment polarity. 1 = common cathode, segment on = 1. 0 = common anode, all segment bits inverted.
- `LED1`  out  7: ones digit, bits [6:0] = segments a,b,c,d,e,f,g.
- `LED2`  out  7: tens digit, same encoding.
- `LED3`  out  7: hundreds digit, same encoding.
- `LED4`  out  7: thousands digit, same encoding.

Port order in the module header is `LED1, LED2, LED3, LED4, clk, enable, LED_TYPE`.

## Operation

- State: four 4-bit BCD digit registers D1 (ones) to D4 (thousands), plus a prescale counter `0..TICK_DIV-1`.
- Reset (`enable`=1):
  - D1..D4 and the prescaler clear immediately, without waiting for a clock edge.
  - Outputs all show "0": 1111110 when `LED_TYPE`=1, 0000001 when `LED_TYPE`=0.
- Tick: occurs on a `clk` rising edge where the prescaler equals `TICK_DIV-1`. Otherwise the prescaler increments. With `TICK_DIV`=1, every edge is a tick.
- Increment on each tick:
  - D1 goes to D1+1; at 9 it wraps to 0 and carries into D2.
  - D2, D3 and D4 behave the same way, each receiving the carry from the digit below.
  - 9999 wraps to 0000 with no flag or stall.
- Decoder (active-high form), digit to a..g:
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - Codes 10–15 are unreachable; they decode to 0000000, which is blank.
- Polarity: `LEDn` = `LED_TYPE` ? pattern : ~pattern. This is applied after decoding, including to the blank code.

## Timing

- Digit registers update only on `clk` rising edges, or asynchronously on reset.
- `LED1..LED4` are combinational from the digit registers and `LED_TYPE`:
  - Zero-cycle latency after a register update.
  - A `LED_TYPE` change takes effect immediately, with no clock needed, and does not alter the count.
- Reset deassertion: the first rising edge after `enable` falls is the first edge that can tick. With `TICK_DIV`=1, the count reads 0001 after that edge.
- A rising edge coincident with `enable` high produces no increment; reset wins.
- Reset asserted mid-count: all outputs return to "0" immediately; the count resumes from 0000 after release.
- All four digits update on the same edge. For example, 0999 to 1000 and 9999 to 0000 occur in one cycle, with no intermediate display states.

## Test plan

- Reset and polarity: hold `enable`=1 with `LED_TYPE`=1.
  - Required: all four LEDs = 1111110.
  - Toggle `LED_TYPE` to 0 without clocking. Required: all four LEDs = 0000001.
- Ones-digit sequence: release reset with `TICK_DIV`=1 and `LED_TYPE`=1, then apply 9 edges.
  - Required: `LED1` steps 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
  - Required: `LED2..LED4` stay 1111110.
- Carry chain:
  - After 10 edges: `LED2`=0110000, `LED1`=1111110.
  - After 999 edges: display 0999.
  - Edge 1000: display 1000 in a single cycle.
- Wrap: apply 9999 edges, giving display 9999 (all 1111011).
  - Required: the next edge gives all 1111110.
- Async reset mid-count: reach count 0042, then assert `enable` between clock edges.
  - Required: outputs show 0000 before the next edge.
  - Release reset; one edge later the display reads 0001.
- Prescaler with `TICK_DIV`=4: apply 8 edges after reset release.
  - Required: display 0002, with changes only on edges 4 and 8.

Source files
------------

// File: rtl/full_bcd_to_led.sv
// Free-running four-digit BCD counter (0000-9999) driving four 7-segment displays.
// LED_TYPE picks common-cathode (1) or common-anode (0) segment polarity.
module full_bcd_to_led #(
  parameter int TICK_DIV = 1
) (
  output logic [6:0] LED1,
  output logic [6:0] LED2,
  output logic [6:0] LED3,
  output logic [6:0] LED4,
  input  logic       clk,
  input  logic       enable,
  input  logic       LED_TYPE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]   prescale_reg;
  logic [PW-1:0]   prescale_next;
  logic            tick;
  logic [3:0]      carry;
  logic [3:0][3:0] digits;
  logic [3:0][6:0] seg_out;

  // Active-high a..g pattern; codes 10-15 cannot occur and show blank.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    s = 7'b0000000;
    case (d)
      4'd0: s = 7'b1111110;
      4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;
      4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;
      4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;
      4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;
      4'd9: s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  assign tick = (prescale_reg == PRE_MAX);

  always_comb begin
    prescale_next = prescale_reg + PW'(1);
    if (tick) begin
      prescale_next = '0;
    end
  end

  always_ff @(posedge clk or posedge enable) begin
    if (enable) begin
      prescale_reg <= '0;
    end else begin
      prescale_reg <= prescale_next;
    end
  end

  assign carry[0] = tick;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] digit_reg;
      logic [3:0] digit_next;

      always_comb begin
        digit_next = digit_reg;
        if (carry[gi]) begin
          digit_next = (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
        end
      end

      always_ff @(posedge clk or posedge enable) begin
        if (enable) begin
          digit_reg <= 4'd0;
        end else begin
          digit_reg <= digit_next;
        end
      end

      // Ripple carry is combinational, so all digits roll over on the same edge.
      if (gi < 3) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit_reg == 4'd9);
      end

      assign digits[gi]  = digit_reg;
      assign seg_out[gi] = LED_TYPE ? bcd_to_seg(digits[gi]) : ~bcd_to_seg(digits[gi]);
    end
  endgenerate

  assign LED1 = seg_out[0];
  assign LED2 = seg_out[1];
  assign LED3 = seg_out[2];
  assign LED4 = seg_out[3];

endmodule

// File: tb/tb_full_bcd_to_led.sv
// Directed bench for full_bcd_to_led: reset/polarity, counting, carries, wrap,
// async reset mid-count and a TICK_DIV=4 instance.
module tb_full_bcd_to_led;

  logic       clk;
  logic       enable;
  logic       enable4;
  logic       led_type;
  logic [6:0] led1, led2, led3, led4;
  logic [6:0] p1, p2, p3, p4;
  int         n_cmp;
  int         n_bad;

  full_bcd_to_led #(.TICK_DIV(1)) dut (
    .LED1(led1), .LED2(led2), .LED3(led3), .LED4(led4),
    .clk(clk), .enable(enable), .LED_TYPE(led_type)
  );

  full_bcd_to_led #(.TICK_DIV(4)) dut4 (
    .LED1(p1), .LED2(p2), .LED3(p3), .LED4(p4),
    .clk(clk), .enable(enable4), .LED_TYPE(led_type)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d, input logic lt);
    logic [6:0] s;
    case (d)
      0: s = 7'b1111110;
      1: s = 7'b0110000;
      2: s = 7'b1101101;
      3: s = 7'b1111001;
      4: s = 7'b0110011;
      5: s = 7'b1011011;
      6: s = 7'b1011111;
      7: s = 7'b1110000;
      8: s = 7'b1111111;
      9: s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return lt ? s : ~s;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input int value, input logic lt);
    chk({tag, ".LED1"}, led1, seg(value % 10, lt));
    chk({tag, ".LED2"}, led2, seg((value / 10) % 10, lt));
    chk({tag, ".LED3"}, led3, seg((value / 100) % 10, lt));
    chk({tag, ".LED4"}, led4, seg((value / 1000) % 10, lt));
    $display("check %s: display %04d", tag, value);
  endtask

  task automatic chk_disp4(input string tag, input int value);
    chk({tag, ".LED1"}, p1, seg(value % 10, 1'b1));
    chk({tag, ".LED2"}, p2, seg((value / 10) % 10, 1'b1));
    chk({tag, ".LED3"}, p3, seg((value / 100) % 10, 1'b1));
    chk({tag, ".LED4"}, p4, seg((value / 1000) % 10, 1'b1));
    $display("check %s: div4 display %04d", tag, value);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    enable   = 1'b1;
    enable4  = 1'b1;
    led_type = 1'b1;

    // Reset holds through edges; check both polarities without clocking.
    edges(3);
    chk_disp("reset_cc", 0, 1'b1);
    led_type = 1'b0;
    #1;
    chk_disp("reset_ca", 0, 1'b0);
    led_type = 1'b1;
    #1;

    // Release between edges; ones digit steps 1..9.
    enable = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      edges(1);
      chk_disp($sformatf("ones_%0d", i), i, 1'b1);
    end
    edges(1);
    chk_disp("carry_10", 10, 1'b1);
    edges(989);
    chk_disp("count_0999", 999, 1'b1);
    edges(1);
    chk_disp("count_1000", 1000, 1'b1);
    edges(8999);
    chk_disp("count_9999", 9999, 1'b1);
    edges(1);
    chk_disp("wrap_0000", 0, 1'b1);

    // Async reset mid-count, asserted between edges.
    edges(42);
    chk_disp("count_0042", 42, 1'b1);
    #3;
    enable = 1'b1;
    #1;
    chk_disp("async_rst", 0, 1'b1);
    @(posedge clk);
    #1;
    enable = 1'b0;
    edges(1);
    chk_disp("after_rst", 1, 1'b1);

    // Polarity flip leaves the count alone.
    led_type = 1'b0;
    #1;
    chk_disp("flip_ca", 1, 1'b0);
    led_type = 1'b1;
    #1;
    chk_disp("flip_back", 1, 1'b1);

    // TICK_DIV=4 instance: changes only on edges 4 and 8.
    chk_disp4("div4_rst", 0);
    enable4 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      edges(1);
      chk_disp4($sformatf("div4_e%0d", i), i / 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
